// File: rtl/carry_bypass_pkg.sv
// Shared sizing helpers for the pipelined carry-bypass adder.
// Geometry: NBLK bypass blocks, spread evenly over the pipeline stages.
package carry_bypass_pkg;

  function automatic int nblk(input int w, input int blk);
    return w / blk;
  endfunction

  function automatic int bps(input int w, input int blk, input int st);
    return (w / blk) / st;
  endfunction

  function automatic bit cfg_ok(input int w, input int blk, input int st);
    return (blk > 0) && (st > 0) && (w % blk == 0) && ((w / blk) % st == 0);
  endfunction

endpackage

// File: rtl/cba_block.sv
// One carry-bypass block: ripple inside, skip the ripple when all bits
// propagate. Purely combinational.
module cba_block
  import carry_bypass_pkg::*;
#(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co,
  output logic           c_msb
);
  logic [BLK:0]   c;
  logic [BLK-1:0] p;

  always_comb begin
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int j = 0; j < BLK; j++) begin
      c[j+1] = (a[j] & b[j]) | (p[j] & c[j]);
    end
    s     = p ^ c[BLK-1:0];
    co    = (&p) ? ci : c[BLK];
    c_msb = c[BLK-1];
  end

endmodule

// File: rtl/carry_bypass_adder_pipe.sv
// Skewed-pipeline carry-bypass adder/subtractor, valid/ready stream.
// Stage k resolves its slice of blocks from the carry of stage k-1.
module carry_bypass_adder_pipe
  import carry_bypass_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NBLK = nblk(WIDTH, BLK);
  localparam int BPS  = bps(WIDTH, BLK, STAGES);
  localparam int SW   = BPS * BLK;

  if (!cfg_ok(WIDTH, BLK, STAGES)) begin : g_bad_cfg
    $error("carry_bypass_adder_pipe: bad WIDTH/BLK/STAGES");
  end

  typedef struct packed {
    logic [WIDTH-1:0] sum_lo;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic             carry;
    logic             c_msb;
  } stage_t;

  stage_t            prv  [STAGES];
  stage_t            st_d [STAGES];
  stage_t            st_q [STAGES];
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  blk_s;
  logic [NBLK-1:0]   blk_co;
  logic              msb_c;

  // Stage 0 sees the ports; b is pre-inverted so later stages only add.
  always_comb begin
    prv[0].sum_lo = '0;
    prv[0].a_hi   = a;
    prv[0].b_hi   = b ^ {WIDTH{sub}};
    prv[0].carry  = cin | sub;
    prv[0].c_msb  = 1'b0;
    vin[0]        = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      prv[k] = st_q[k-1];
      vin[k] = v_q[k-1];
    end
  end

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    localparam int K = i / BPS;
    logic ci;
    logic co;
    logic cm;
    if (i % BPS == 0) begin : g_head
      assign ci = prv[K].carry;
    end else begin : g_chain
      assign ci = g_blk[i-1].co;
    end
    cba_block #(.BLK(BLK)) u_blk (
      .a    (prv[K].a_hi[i*BLK +: BLK]),
      .b    (prv[K].b_hi[i*BLK +: BLK]),
      .ci   (ci),
      .s    (blk_s[i*BLK +: BLK]),
      .co   (co),
      .c_msb(cm)
    );
    assign blk_co[i] = co;
    if (i == NBLK - 1) begin : g_msb
      assign msb_c = cm;
    end
  end

  always_comb begin
    ld[STAGES-1] = !v_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      ld[k] = !v_q[k] || ld[k+1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      st_d[k] = st_q[k];
      v_d[k]  = ld[k] ? vin[k] : v_q[k];
      if (ld[k] && vin[k]) begin
        st_d[k]                  = prv[k];
        st_d[k].sum_lo[k*SW +: SW] = blk_s[k*SW +: SW];
        st_d[k].carry            = blk_co[k*BPS + BPS - 1];
        if (k == STAGES - 1) begin
          st_d[k].c_msb = msb_c;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = st_q[STAGES-1].sum_lo;
  assign cout      = st_q[STAGES-1].carry;
  assign ovf       = st_q[STAGES-1].carry ^ st_q[STAGES-1].c_msb;

endmodule
